// File: rtl/sa_pkg.sv
// Shared definitions for the output-stationary systolic matmul core.
//   - default geometry and widths of the array
//   - control FSM state encoding
//   - signed element types at the default widths
package sa_pkg;

  localparam int DEF_R  = 4;
  localparam int DEF_C  = 4;
  localparam int DEF_WK = 8;
  localparam int DEF_WX = 8;
  localparam int DEF_WA = 32;
  localparam int DEF_WY = 32;
  localparam int DEF_LM = 1;
  localparam int DEF_LA = 1;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  typedef logic signed [DEF_WK-1:0] wk_t;
  typedef logic signed [DEF_WX-1:0] wx_t;
  typedef logic signed [DEF_WA-1:0] wa_t;

endpackage

// File: rtl/sa_axis_core_pe.sv
// One processing element of the output-stationary array.
// It multiplies one pixel by one weight per valid beat, pipelines the product
// through LM stages, and accumulates into a local sum that is either
// overwritten (first beat of an op) or added to. The accumulated value is then
// presented through LA-1 further delay stages, so acc_out is settled LM+LA
// cycles after the last beat.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   vld_in     a k/x beat is accepted this cycle
//   first_in   this beat is the first of an operation (overwrite the sum)
//   k_in       signed weight
//   x_in       signed pixel
//   acc_out    signed accumulated sum (wraps modulo 2^WA)
module sa_pe
  import sa_pkg::*;
#(
  parameter int WK = DEF_WK,
  parameter int WX = DEF_WX,
  parameter int WA = DEF_WA,
  parameter int LM = DEF_LM,
  parameter int LA = DEF_LA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_in,
  input  logic                 first_in,
  input  logic signed [WK-1:0] k_in,
  input  logic signed [WX-1:0] x_in,
  output logic signed [WA-1:0] acc_out
);

  localparam int WP = WK + WX;

  logic signed [WP-1:0] prod_p [LM];
  logic                 vld_p   [LM];
  logic                 first_p [LM];
  logic signed [WA-1:0] acc_p  [LA];
  logic signed [WA-1:0] prod_ext;

  // Multiplier pipeline: stage 0 holds the fresh product, LM-1 feeds the adder
  always_ff @(posedge clk) begin
    prod_p[0] <= WP'(x_in) * WP'(k_in);
    for (int i = 1; i < LM; i++) begin
      prod_p[i] <= prod_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LM; i++) begin
        vld_p[i]   <= 1'b0;
        first_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0]   <= vld_in;
      first_p[0] <= first_in;
      for (int i = 1; i < LM; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
      end
    end
  end

  assign prod_ext = WA'(prod_p[LM-1]);

  // Accumulator stage: acc_p[0] is the running sum, the rest only delay it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LA; i++) begin
        acc_p[i] <= '0;
      end
    end else begin
      if (vld_p[LM-1]) begin
        acc_p[0] <= first_p[LM-1] ? prod_ext : acc_p[0] + prod_ext;
      end
      for (int i = 1; i < LA; i++) begin
        acc_p[i] <= acc_p[i-1];
      end
    end
  end

  assign acc_out = acc_p[LA-1];

endmodule

// File: rtl/sa_axis_core.sv
// Output-stationary R x C systolic matrix-multiply core with AXI-Stream ports.
// Computes Y[r][c] = A[r][c] + sum_k X[k][r]*K[k][c].
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   s_k_tdata/tvalid/tready/tlast     weight rows K[k][0..C-1]; tlast ends the op
//   s_x_tdata/tvalid/tready/tlast     pixel columns X[k][0..R-1]; tlast ignored
//   s_a_tdata/tvalid/tready           partial-sum rows A[r][0..C-1]
//   m_y_tdata/tvalid/tready/tlast     result rows Y[r][0..C-1]; tlast on row R-1
// Flow: ACC (accept joint k/x beats) -> DRAIN (LM+LA cycles) -> OUT (R rows).
module sa_axis_core
  import sa_pkg::*;
#(
  parameter int R  = DEF_R,
  parameter int C  = DEF_C,
  parameter int WK = DEF_WK,
  parameter int WX = DEF_WX,
  parameter int WA = DEF_WA,
  parameter int WY = DEF_WY,
  parameter int LM = DEF_LM,
  parameter int LA = DEF_LA
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [C*WK-1:0] s_k_tdata,
  input  logic            s_k_tvalid,
  output logic            s_k_tready,
  input  logic            s_k_tlast,
  input  logic [R*WX-1:0] s_x_tdata,
  input  logic            s_x_tvalid,
  output logic            s_x_tready,
  input  logic            s_x_tlast,
  input  logic [C*WA-1:0] s_a_tdata,
  input  logic            s_a_tvalid,
  output logic            s_a_tready,
  output logic [C*WY-1:0] m_y_tdata,
  output logic            m_y_tvalid,
  input  logic            m_y_tready,
  output logic            m_y_tlast
);

  localparam int RW      = $clog2(R + 1);
  localparam int DRAIN_N = LM + LA;
  localparam int DW      = $clog2(DRAIN_N + 1);

  function automatic logic [WY-1:0] trunc_y(input logic signed [WA-1:0] v);
    return v[WY-1:0];
  endfunction

  state_t         state, state_nxt;
  logic [RW-1:0]  row_cnt;
  logic [DW-1:0]  drain_cnt;
  logic           first_beat;
  logic           kx_fire;
  logic           a_fire;
  logic           y_fire;
  logic           unused_x_tlast;

  logic signed [WK-1:0] k_elem [C];
  logic signed [WX-1:0] x_elem [R];
  logic signed [WA-1:0] a_elem [C];
  logic signed [WA-1:0] acc     [R][C];
  logic signed [WA-1:0] acc_row [C];
  logic signed [WA-1:0] sum_row [C];
  logic [C*WY-1:0]      y_row;

  assign unused_x_tlast = s_x_tlast;

  for (genvar gc = 0; gc < C; gc++) begin : g_unpack_c
    assign k_elem[gc] = s_k_tdata[gc*WK +: WK];
    assign a_elem[gc] = s_a_tdata[gc*WA +: WA];
  end
  for (genvar gr = 0; gr < R; gr++) begin : g_unpack_r
    assign x_elem[gr] = s_x_tdata[gr*WX +: WX];
  end

  for (genvar gr = 0; gr < R; gr++) begin : g_row
    for (genvar gc = 0; gc < C; gc++) begin : g_col
      sa_pe #(
        .WK(WK), .WX(WX), .WA(WA), .LM(LM), .LA(LA)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (kx_fire),
        .first_in(first_beat),
        .k_in    (k_elem[gc]),
        .x_in    (x_elem[gr]),
        .acc_out (acc[gr][gc])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (kx_fire && s_k_tlast) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DW'(DRAIN_N - 1)) state_nxt = ST_OUT;
      ST_OUT:   if (y_fire && m_y_tlast) state_nxt = ST_ACC;
      default:  state_nxt = ST_ACC;
    endcase
  end

  // Ready signals are forced low while reset is held so nothing fires during it.
  // In OUT, a rows stop being taken once all R rows have been issued.
  always_comb begin
    s_k_tready = 1'b0;
    s_x_tready = 1'b0;
    s_a_tready = 1'b0;
    case (state)
      ST_ACC: begin
        s_k_tready = ~rst & s_k_tvalid & s_x_tvalid;
        s_x_tready = ~rst & s_k_tvalid & s_x_tvalid;
      end
      ST_OUT: begin
        s_a_tready = ~rst & (row_cnt != RW'(R)) & (~m_y_tvalid | m_y_tready);
      end
      default: ;
    endcase
  end

  assign kx_fire = s_k_tready;
  assign a_fire  = s_a_tvalid & s_a_tready;
  assign y_fire  = m_y_tvalid & m_y_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt  <= '0;
      row_cnt    <= '0;
      first_beat <= 1'b1;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
      if (kx_fire) first_beat <= 1'b0;
      if (y_fire && m_y_tlast) begin
        first_beat <= 1'b1;
        row_cnt    <= '0;
      end else if (a_fire) begin
        row_cnt <= row_cnt + RW'(1);
      end
    end
  end

  always_comb begin
    y_row = '0;
    for (int c = 0; c < C; c++) begin
      acc_row[c] = '0;
      for (int r = 0; r < R; r++) begin
        if (row_cnt == RW'(r)) acc_row[c] = acc[r][c];
      end
      sum_row[c] = acc_row[c] + a_elem[c];
      y_row[c*WY +: WY] = trunc_y(sum_row[c]);
    end
  end

  // Output register: loads on an a beat, holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      m_y_tvalid <= 1'b0;
      m_y_tlast  <= 1'b0;
      m_y_tdata  <= '0;
    end else if (a_fire) begin
      m_y_tvalid <= 1'b1;
      m_y_tlast  <= (row_cnt == RW'(R - 1));
      m_y_tdata  <= y_row;
    end else if (y_fire) begin
      m_y_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_axis_core.sv
module tb_sa_axis_core;
  localparam int R = 4, C = 4, WK = 8, WX = 8, WA = 32, WY = 32, LM = 1, LA = 1;

  logic            clk, rst;
  logic [C*WK-1:0] s_k_tdata;
  logic            s_k_tvalid, s_k_tready, s_k_tlast;
  logic [R*WX-1:0] s_x_tdata;
  logic            s_x_tvalid, s_x_tready, s_x_tlast;
  logic [C*WA-1:0] s_a_tdata;
  logic            s_a_tvalid, s_a_tready;
  logic [C*WY-1:0] m_y_tdata;
  logic            m_y_tvalid, m_y_tready, m_y_tlast;

  sa_axis_core #(.R(R), .C(C), .WK(WK), .WX(WX), .WA(WA), .WY(WY), .LM(LM), .LA(LA)) dut (
    .clk(clk), .rst(rst),
    .s_k_tdata(s_k_tdata), .s_k_tvalid(s_k_tvalid), .s_k_tready(s_k_tready), .s_k_tlast(s_k_tlast),
    .s_x_tdata(s_x_tdata), .s_x_tvalid(s_x_tvalid), .s_x_tready(s_x_tready), .s_x_tlast(s_x_tlast),
    .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
    .m_y_tdata(m_y_tdata), .m_y_tvalid(m_y_tvalid), .m_y_tready(m_y_tready), .m_y_tlast(m_y_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference operands of the current operation
  int km [16][C];
  int xm [16][R];
  int am [R][C];
  int nb;
  int fixed_en;
  int fixed_val;

  function automatic int model_y(input int r, input int c);
    int s;
    s = am[r][c];
    for (int k = 0; k < nb; k++) s += xm[k][r] * km[k][c];
    return s;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic fill_random(input int beats);
    nb = beats;
    fixed_en = 0;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < C; c++) km[k][c] = rnd8();
      for (int r = 0; r < R; r++) xm[k][r] = rnd8();
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) am[r][c] = int'($urandom);
  endtask

  task automatic send_kx(input int gap_pct);
    int k;
    int cyc;
    logic kv, xv;
    k = 0;
    cyc = 0;
    while (k < nb && cyc < 2000) begin
      @(negedge clk);
      kv = ($urandom_range(99) >= gap_pct);
      xv = ($urandom_range(99) >= gap_pct);
      s_k_tvalid = kv;
      s_x_tvalid = xv;
      for (int c = 0; c < C; c++) s_k_tdata[c*WK +: WK] = km[k][c][WK-1:0];
      for (int r = 0; r < R; r++) s_x_tdata[r*WX +: WX] = xm[k][r][WX-1:0];
      s_k_tlast = (k == nb - 1);
      s_x_tlast = 1'($urandom_range(1));
      #1;
      n_cmp++;
      if (s_k_tready !== (kv & xv) || s_x_tready !== (kv & xv)) begin
        n_bad++;
        $display("FAIL kx_ready: got k=%b x=%b required %b", s_k_tready, s_x_tready, kv & xv);
      end
      if (kv && xv) k++;
      cyc++;
      @(posedge clk);
    end
    if (k < nb) begin
      n_bad++;
      $display("FAIL kx_timeout: accepted %0d beats required %0d", k, nb);
    end
  endtask

  task automatic recv_y(input int rdy_pct, input int stop_after);
    int sent, got, cyc, idx, exp;
    logic [WY-1:0] expv;
    logic [C*WY-1:0] prev_d;
    logic prev_last;
    bit prev_stall;
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 0;
    prev_d = '0;
    prev_last = 1'b0;
    while (got < stop_after && cyc < 500) begin
      @(negedge clk);
      idx = (sent < R) ? sent : 0;
      s_a_tvalid = (sent < R) && ($urandom_range(99) < 80);
      for (int c = 0; c < C; c++) s_a_tdata[c*WA +: WA] = am[idx][c];
      m_y_tready = ($urandom_range(99) < rdy_pct);
      s_k_tvalid = 1'($urandom_range(1));
      s_x_tvalid = 1'($urandom_range(1));
      #1;
      n_cmp++;
      if (s_k_tready !== 1'b0 || s_x_tready !== 1'b0) begin
        n_bad++;
        $display("FAIL kx_blocked: got k=%b x=%b required 0", s_k_tready, s_x_tready);
      end
      if (prev_stall) begin
        n_cmp++;
        if (m_y_tvalid !== 1'b1 || m_y_tdata !== prev_d || m_y_tlast !== prev_last) begin
          n_bad++;
          $display("FAIL y_stable: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   m_y_tvalid, m_y_tdata, m_y_tlast, prev_d, prev_last);
        end
      end
      if (m_y_tvalid && m_y_tready) begin
        for (int c = 0; c < C; c++) begin
          exp = fixed_en ? fixed_val : model_y(got, c);
          expv = exp[WY-1:0];
          n_cmp++;
          if (m_y_tdata[c*WY +: WY] !== expv) begin
            n_bad++;
            $display("FAIL y_data r%0d c%0d: got %h required %h", got, c, m_y_tdata[c*WY +: WY], expv);
          end
        end
        n_cmp++;
        if (m_y_tlast !== (got == R - 1)) begin
          n_bad++;
          $display("FAIL y_tlast r%0d: got %b required %b", got, m_y_tlast, got == R - 1);
        end
        got++;
      end
      if (s_a_tvalid && s_a_tready) sent++;
      prev_stall = m_y_tvalid && !m_y_tready;
      prev_d = m_y_tdata;
      prev_last = m_y_tlast;
      cyc++;
      @(posedge clk);
    end
    if (got < stop_after) begin
      n_bad++;
      $display("FAIL y_timeout: got %0d rows required %0d", got, stop_after);
    end
    if (stop_after == R) begin
      @(negedge clk);
      s_k_tvalid = 1'b0;
      s_x_tvalid = 1'b0;
      s_a_tvalid = 1'b0;
      #1;
      n_cmp++;
      if (m_y_tvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL y_extra: got tvalid=%b required 0", m_y_tvalid);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    s_k_tvalid = 1'b1;
    s_x_tvalid = 1'b1;
    s_a_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({s_k_tready, s_x_tready, s_a_tready, m_y_tvalid, m_y_tlast} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {s_k_tready, s_x_tready, s_a_tready, m_y_tvalid, m_y_tlast});
    end
    n_cmp++;
    if (m_y_tdata !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h required 0", m_y_tdata);
    end
    rst = 1'b0;
    s_k_tvalid = 1'b0;
    s_x_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (s_a_tready !== 1'b0 || m_y_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got a_rdy=%b y_vld=%b required 0 0", s_a_tready, m_y_tvalid);
    end
    s_a_tvalid = 1'b0;
  endtask

  task automatic test_single_beat();
    nb = 1;
    for (int c = 0; c < C; c++) km[0][c] = 1;
    for (int r = 0; r < R; r++) xm[0][r] = 2;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) am[r][c] = 0;
    fixed_en = 1;
    fixed_val = 2;
    send_kx(0);
    recv_y(100, R);
  endtask

  task automatic test_accumulate();
    nb = 3;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < C; c++) km[k][c] = k + 1;
      for (int r = 0; r < R; r++) xm[k][r] = 1;
    end
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) am[r][c] = 10;
    fixed_en = 1;
    fixed_val = 16;
    send_kx(0);
    recv_y(100, R);
  endtask

  task automatic test_sign();
    nb = 1;
    for (int c = 0; c < C; c++) km[0][c] = -1;
    for (int r = 0; r < R; r++) xm[0][r] = 127;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) am[r][c] = 100;
    fixed_en = 1;
    fixed_val = 32'hFFFFFFE5;
    send_kx(0);
    recv_y(100, R);
  endtask

  task automatic test_backpressure();
    for (int op = 0; op < 6; op++) begin
      fill_random(int'($urandom_range(1, 12)));
      send_kx(40);
      recv_y(50, R);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(5);
    for (int k = 0; k < nb; k++) for (int c = 0; c < C; c++) km[k][c] = 127;
    for (int k = 0; k < nb; k++) for (int r = 0; r < R; r++) xm[k][r] = -128;
    send_kx(0);
    recv_y(100, R);
    fill_random(2);
    send_kx(0);
    recv_y(100, R);
    fill_random(1);
    send_kx(0);
    recv_y(100, R);
  endtask

  task automatic test_reset_mid_out();
    fill_random(2);
    send_kx(0);
    recv_y(100, 2);
    @(negedge clk);
    rst = 1'b1;
    s_k_tvalid = 1'b1;
    s_x_tvalid = 1'b1;
    s_a_tvalid = 1'b1;
    m_y_tready = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({s_k_tready, s_x_tready, s_a_tready, m_y_tvalid} !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b required 0000", {s_k_tready, s_x_tready, s_a_tready, m_y_tvalid});
    end
    @(negedge clk);
    rst = 1'b0;
    s_k_tvalid = 1'b0;
    s_x_tvalid = 1'b0;
    #1;
    n_cmp++;
    if (s_a_tready !== 1'b0 || m_y_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_acc: got a_rdy=%b y_vld=%b required 0 0", s_a_tready, m_y_tvalid);
    end
    s_a_tvalid = 1'b0;
    fill_random(3);
    send_kx(20);
    recv_y(70, R);
  endtask

  initial begin
    rst = 1'b1;
    s_k_tdata = '0; s_k_tvalid = 1'b0; s_k_tlast = 1'b0;
    s_x_tdata = '0; s_x_tvalid = 1'b0; s_x_tlast = 1'b0;
    s_a_tdata = '0; s_a_tvalid = 1'b0;
    m_y_tready = 1'b0;
    fixed_en = 0;
    fixed_val = 0;
    nb = 0;
    test_reset();
    test_single_beat();
    test_accumulate();
    test_sign();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
